// File: rtl/draw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : draw_pkg                                                  |
// | Brief    : Shared state encoding, drawable-area defaults and helpers |
// |            for the pixel-drawing blocks (arbiter, blink, ASCII).     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package draw_pkg;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } draw_state_t;

  // Default drawable area of the VGA fill block
  localparam int c_h_res_def = 160;
  localparam int c_v_res_def = 120;

  // Convert a one-hot vector (up to 8 clients) to its index
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/draw_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_pick                                                   |
// | Brief    : Combinational winner selection. Round-robin search from   |
// |            a start pointer, or fixed priority (lowest index wins).   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   pointer,
  input  logic         mode,     // 1 = round-robin from pointer, 0 = fixed priority
  output logic [N-1:0] win,
  output logic         valid
);

  logic [3:0] w_idx;
  logic       w_found;

  // Walk candidates in search order and take the first requester
  always_comb begin
    win     = '0;
    w_found = 1'b0;
    w_idx   = 4'd0;
    for (int k = 0; k < N; k++) begin
      w_idx = mode ? (4'(pointer) + 4'(k)) : 4'(k);
      if (w_idx >= 4'(N)) w_idx = w_idx - 4'(N);
      for (int j = 0; j < N; j++) begin
        if (!w_found && (w_idx == 4'(j)) && req[j]) begin
          win[j]  = 1'b1;
          w_found = 1'b1;
        end
      end
    end
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/draw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : draw_arbiter                                              |
// | Brief    : Shares one VGA pixel-write port among N draw clients.     |
// |            Registers the owner's pixel, clips to the drawable area   |
// |            and inserts a one-cycle gap between owners.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int X_W       = 9,
  parameter int Y_W       = 9,
  parameter int COLOR_W   = 3,
  parameter int RR_MODE   = 1,
  parameter int MAX_HOLD  = 0,
  parameter int H_RES     = c_h_res_def,
  parameter int V_RES     = c_v_res_def
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [N_CLIENTS-1:0]         req,
  input  logic [N_CLIENTS-1:0]         done,
  input  logic [N_CLIENTS-1:0]         cen,
  input  logic [N_CLIENTS*X_W-1:0]     cx,
  input  logic [N_CLIENTS*Y_W-1:0]     cy,
  input  logic [N_CLIENTS*COLOR_W-1:0] ccolor,
  output logic [N_CLIENTS-1:0]         gnt,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOR_W-1:0]           out_color,
  output logic                         writeEn,
  output logic [2:0]                   owner,
  output logic                         busy,
  output logic                         clipped
);

  localparam int c_hold_w = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  draw_state_t            state_q, state_d;
  logic [N_CLIENTS-1:0]   gnt_q, gnt_d;
  logic [2:0]             owner_q, owner_d;
  logic [2:0]             last_owner_q, last_owner_d;
  logic [c_hold_w-1:0]    hold_q, hold_d;
  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [COLOR_W-1:0]     color_q, color_d;
  logic                   we_q, we_d;
  logic                   clipped_q, clipped_d;

  logic [X_W-1:0]         w_sel_x;
  logic [Y_W-1:0]         w_sel_y;
  logic [COLOR_W-1:0]     w_sel_color;
  logic                   w_sel_cen;
  logic                   w_sel_done;
  logic                   w_sel_req;
  logic                   w_clip;
  logic                   w_timeout;
  logic                   w_release;
  logic [2:0]             w_ptr;
  logic [N_CLIENTS-1:0]   w_win;
  logic                   w_valid;

  // Round-robin search starts just past the last owner
  assign w_ptr = (last_owner_q >= 3'(N_CLIENTS - 1)) ? 3'd0 : last_owner_q + 3'd1;

  rr_pick #(
    .N (N_CLIENTS)
  ) u_rr_pick (
    .req     (req),
    .pointer (w_ptr),
    .mode    (RR_MODE != 0),
    .win     (w_win),
    .valid   (w_valid)
  );

  // Mux the current owner's signals; owner_q only ever holds a valid index
  always_comb begin
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_color = '0;
    w_sel_cen   = 1'b0;
    w_sel_done  = 1'b0;
    w_sel_req   = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (owner_q == 3'(i)) begin
        w_sel_x     = cx[i*X_W +: X_W];
        w_sel_y     = cy[i*Y_W +: Y_W];
        w_sel_color = ccolor[i*COLOR_W +: COLOR_W];
        w_sel_cen   = cen[i];
        w_sel_done  = done[i];
        w_sel_req   = req[i];
      end
    end
  end

  assign w_clip    = ({1'b0, w_sel_x} >= (X_W + 1)'(H_RES)) ||
                     ({1'b0, w_sel_y} >= (Y_W + 1)'(V_RES));
  assign w_timeout = (MAX_HOLD > 0) && (int'(hold_q) == MAX_HOLD - 1);
  assign w_release = w_sel_done || !w_sel_req || w_timeout;

  // Next-state, grant and pixel-path logic
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
    we_d         = 1'b0;
    clipped_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (w_valid) begin
          state_d = ST_OWN;
          gnt_d   = w_win;
          owner_d = onehot_to_idx(8'(w_win));
          hold_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        // Pixel is written even on the releasing cycle
        x_d       = w_sel_x;
        y_d       = w_sel_y;
        color_d   = w_sel_color;
        we_d      = w_sel_cen & ~w_clip;
        clipped_d = w_sel_cen & w_clip;
        if (hold_q != '1) hold_d = hold_q + 1'b1;
        if (w_release) begin
          state_d      = ST_GAP;
          gnt_d        = '0;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      owner_q      <= 3'd0;
      last_owner_q <= 3'(N_CLIENTS - 1);
      hold_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      we_q         <= 1'b0;
      clipped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      we_q         <= we_d;
      clipped_q    <= clipped_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign x         = x_q;
  assign y         = y_q;
  assign out_color = color_q;
  assign writeEn   = we_q;
  assign clipped   = clipped_q;
  assign busy      = (state_q == ST_OWN);

endmodule
`default_nettype wire

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 SHALL have parameter N_CLIENTS, default 2, number of pixel-draw clients (range 2..8).
REQ-002 SHALL have parameter X_W, default 9, x-coordinate width.
REQ-003 SHALL have parameter Y_W, default 9, y-coordinate width.
REQ-004 SHALL have parameter COLOR_W, default 3, pixel colour width.
REQ-005 SHALL have parameter RR_MODE, default 1; 1 = round-robin, 0 = fixed priority with lowest index highest.
REQ-006 SHALL have parameter MAX_HOLD, default 0, grant timeout in cycles; 0 = no timeout.
REQ-007 SHALL have parameters H_RES, default 160, and V_RES, default 120, giving the drawable area.
REQ-008 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-009 reset  in  1  synchronous, active-low reset.
REQ-010 req  in  N_CLIENTS  per-client request to own the pixel port.
REQ-011 done  in  N_CLIENTS  per-client end-of-burst pulse.
REQ-012 cen  in  N_CLIENTS  per-client pixel write enable.
REQ-013 cx  in  N_CLIENTS*X_W  packed client x; client i occupies bits [i*X_W +: X_W]. cy (Y_W) and ccolor (COLOR_W) use the same packing.
REQ-014 gnt  out  N_CLIENTS  one-hot grant, registered.
REQ-015 x, y, out_color  out  X_W, Y_W, COLOR_W  registered pixel to the VGA fill block.
REQ-016 writeEn  out  1  registered pixel strobe.
REQ-017 owner  out  3  index of the current owner; valid only while busy.
REQ-018 busy  out  1  high while in state OWN.
REQ-019 clipped  out  1  one-cycle pulse when the owner's write is suppressed by clipping.

Function
REQ-020 SHALL implement states IDLE, OWN and GAP.
REQ-021 IDLE: on any req bit, SHALL select a winner, set gnt/owner on the next edge and enter OWN; no req SHALL keep IDLE.
REQ-022 Round-robin: search SHALL start at index (last_owner+1) mod N_CLIENTS; last_owner resets to N_CLIENTS-1, so client 0 wins first.
REQ-023 Fixed priority: the lowest set req index SHALL win.
REQ-024 OWN: each cycle SHALL register cx/cy/ccolor of the owner into x/y/out_color and cen[owner] into writeEn (1-cycle latency).
REQ-025 A non-owner's cen SHALL never reach writeEn.
REQ-026 Clipping: if the owner's x >= H_RES or y >= V_RES while cen is high, writeEn SHALL be 0 and clipped SHALL be 1 for that cycle.
REQ-027 Release SHALL occur when done[owner]=1, or req[owner]=0, or the hold counter reaches MAX_HOLD-1 (MAX_HOLD>0); the state SHALL go to GAP with gnt cleared.
REQ-028 A cen coincident with the releasing done SHALL still be written.
REQ-029 GAP: lasts exactly one cycle with writeEn=0; it SHALL then arbitrate as in IDLE, going to OWN if any req is set, otherwise to IDLE.
REQ-030 Hold counter: width clog2(MAX_HOLD+1); SHALL clear on entry to OWN and saturate rather than wrap.
REQ-031 In round-robin mode, a client released by timeout or done that still requests SHALL win again only if no other client requests.
REQ-032 done/cen from non-owners SHALL be ignored; req changes in OWN SHALL not pre-empt the owner.
REQ-033 Out-of-range owner index (N_CLIENTS < 8) SHALL be impossible by construction.

Reset
REQ-034 While reset=0 at an edge: state IDLE, gnt=0, x=0, y=0, out_color=0, writeEn=0, owner=0, busy=0, clipped=0, hold counter 0, last_owner=N_CLIENTS-1.
REQ-035 Reset asserted mid-burst SHALL take effect on the next edge, dropping writeEn without completing the burst.

Structure
REQ-036 State encoding and the default H_RES/V_RES SHALL live in shared package draw_pkg, shared with the blink and ASCII display blocks.
REQ-037 Winner selection SHALL be one sub-module, rr_pick (req, pointer, mode -> one-hot winner, valid), purely combinational.

Verification
REQ-038 N=2, RR: req=2'b11 from reset -> gnt=01 after 1 cycle; done[0] -> GAP 1 cycle -> gnt=10.
REQ-039 Owner 1, cx=5, cy=7, ccolor=3'b100, cen=1 -> next cycle x=5, y=7, out_color=4, writeEn=1; cen[0]=1 alone produces no write.
REQ-040 Owner writes x=160, y=10 with cen=1 -> writeEn=0 and clipped=1 for one cycle; x=159 is written.
REQ-041 MAX_HOLD=4, client 0 holds req with no done and client 1 requests -> after 4 OWN cycles, GAP, then gnt=10.
REQ-042 RR_MODE=0, N=4, req=4'b1100, then req[2]=0 in GAP -> client 3 granted; req=4'b1111 -> client 0 wins every time.
REQ-043 reset=0 during an active burst -> all outputs 0 at the next edge; after release, req=2'b10 -> gnt=10.
